// File: rtl/text_fetcher.sv
// text_fetcher: text-mode character fetch stage ahead of the font renderer.
// Walks the character-code text RAM in step with display timing and presents
// the current character, pixel column, glyph scanline and prefetched next
// character on every active pixel clock.
//
// Ports:
//   clk, rst_n            pixel clock, asynchronous active-low reset
//   frame_req, line_req   frame / line start pulses from display timing
//   active                high during the active pixels of a line
//   ram_rd, ram_addr      text RAM read strobe and address (row*COLS + col)
//   ram_data              char code, valid the cycle after ram_rd
//   char, x, y            current character, pixel column in cell, scanline
//   next_char, next_y     following cell's character and its scanline
//   enable                renderer enable (combinational from active)
//   underrun              sticky: active arrived before the first char loaded
module text_fetcher #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 30,
  parameter int          COL_WIDTH  = 8,
  parameter int          ROW_HEIGHT = 16,
  parameter int          ADDR_W     = $clog2(COLS*ROWS),
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_req,
  input  logic                          line_req,
  input  logic                          active,
  output logic                          ram_rd,
  output logic [ADDR_W-1:0]             ram_addr,
  input  logic [7:0]                    ram_data,
  output logic [7:0]                    char,
  output logic [$clog2(COL_WIDTH)-1:0]  x,
  output logic [$clog2(ROW_HEIGHT)-1:0] y,
  output logic [7:0]                    next_char,
  output logic [$clog2(ROW_HEIGHT)-1:0] next_y,
  output logic                          enable,
  output logic                          underrun
);

  localparam int XW = $clog2(COL_WIDTH);
  localparam int YW = $clog2(ROW_HEIGHT);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH0 = 3'd1;
  localparam logic [2:0] S_WAIT0  = 3'd2;
  localparam logic [2:0] S_READY  = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [YW-1:0]     y_q, y_d;
  logic [CW-1:0]     col_q, col_d;
  logic [XW-1:0]     x_q, x_d;
  logic [7:0]        char_q, char_d;
  logic [7:0]        next_char_q, next_char_d;
  logic              ram_rd_q, ram_rd_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              underrun_q, underrun_d;
  logic              rd_vld_q;   // read issued last cycle, ram_data valid now
  logic              step;       // one active pixel consumed this cycle

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    row_base_d  = row_base_q;
    y_d         = y_q;
    col_d       = col_q;
    x_d         = x_q;
    char_d      = char_q;
    next_char_d = next_char_q;
    ram_rd_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    underrun_d  = underrun_q;
    step        = 1'b0;

    if (frame_req) begin
      state_d     = S_IDLE;
      row_d       = '0;
      row_base_d  = '0;
      y_d         = '0;
      col_d       = '0;
      x_d         = '0;
      char_d      = BLANK_CHAR;
      next_char_d = BLANK_CHAR;
      ram_addr_d  = '0;
    end

    // Frame reset above is applied first, so a coincident line starts at row 0.
    if (line_req) begin
      state_d    = S_FETCH0;
      col_d      = '0;
      x_d        = '0;
      ram_rd_d   = 1'b1;
      ram_addr_d = row_base_d;
    end else if (!frame_req) begin
      case (state_q)
        S_IDLE: begin
          if (active) underrun_d = 1'b1;
        end
        S_FETCH0: begin
          if (active) begin
            underrun_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            state_d = S_WAIT0;
          end
        end
        S_WAIT0: begin
          if (active) begin
            underrun_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            char_d      = ram_data;
            next_char_d = BLANK_CHAR;
            state_d     = S_READY;
            // The col-1 read is registered so it is on the bus during the
            // first READY cycle, i.e. x==0 of col 0 when active rises earliest.
            if (COLS > 1) begin
              ram_rd_d   = 1'b1;
              ram_addr_d = ram_addr_q + ADDR_W'(1);
            end
          end
        end
        S_READY: begin
          if (rd_vld_q) next_char_d = ram_data;
          if (active) begin
            state_d = S_RUN;
            step    = 1'b1;
          end
        end
        S_RUN: begin
          if (rd_vld_q) next_char_d = ram_data;
          if (active) begin
            step = 1'b1;
          end else begin
            state_d = S_IDLE;
            if (y_q == YW'(ROW_HEIGHT-1)) begin
              y_d = '0;
              if (row_q == RW'(ROWS-1)) begin
                row_d      = '0;
                row_base_d = '0;
              end else begin
                row_d      = row_q + RW'(1);
                row_base_d = row_base_q + ADDR_W'(COLS);
              end
            end else begin
              y_d = y_q + YW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (step) begin
        if (x_q == XW'(COL_WIDTH-1)) begin
          x_d         = '0;
          char_d      = next_char_q;
          next_char_d = BLANK_CHAR;
          if (col_q != CW'(COLS-1)) col_d = col_q + CW'(1);
          // Registered read for col+2, so it is on the bus at x==0 of col+1.
          if ((int'(col_q) + 2) < COLS) begin
            ram_rd_d   = 1'b1;
            ram_addr_d = ram_addr_q + ADDR_W'(1);
          end
        end else begin
          x_d = x_q + XW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      row_base_q  <= '0;
      y_q         <= '0;
      col_q       <= '0;
      x_q         <= '0;
      char_q      <= BLANK_CHAR;
      next_char_q <= BLANK_CHAR;
      ram_rd_q    <= 1'b0;
      ram_addr_q  <= '0;
      underrun_q  <= 1'b0;
      rd_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      row_base_q  <= row_base_d;
      y_q         <= y_d;
      col_q       <= col_d;
      x_q         <= x_d;
      char_q      <= char_d;
      next_char_q <= next_char_d;
      ram_rd_q    <= ram_rd_d;
      ram_addr_q  <= ram_addr_d;
      underrun_q  <= underrun_d;
      rd_vld_q    <= ram_rd_q;
    end
  end

  assign ram_rd    = ram_rd_q;
  assign ram_addr  = ram_addr_q;
  assign char      = char_q;
  assign x         = x_q;
  assign y         = y_q;
  assign next_char = next_char_q;
  assign next_y    = y_q;
  assign underrun  = underrun_q;
  assign enable    = active && ((state_q == S_READY) || (state_q == S_RUN));

endmodule

// File: doc/text_fetcher.md
# text_fetcher

Text-mode character fetch stage that sits directly upstream of the font renderer. It walks a character-code text RAM in step with the display timing and presents the renderer with the current character, pixel column, glyph scanline and prefetched next character on every active pixel clock. It owns row and scanline tracking, text RAM addressing and the one-cycle RAM read latency, so the renderer sees a continuous, gap-free character stream.

## Interface
- COLS, 80: characters per text row
- ROWS, 30: text rows per frame
- COL_WIDTH, 8: pixels per character cell, horizontally; power of two
- ROW_HEIGHT, 16: scanlines per character cell; power of two
- ADDR_W, $clog2(COLS*ROWS): text RAM address width
- BLANK_CHAR, 8'h20: code presented when no valid character exists
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- frame_req  in  1  pulse; a new frame starts; precedes that frame's first line_req
- line_req  in  1  pulse; an active scanline follows at least 3 cycles later
- active  in  1  high for the active pixels of a line (COLS*COL_WIDTH cycles)
- ram_rd  out  1  text RAM read strobe
- ram_addr  out  ADDR_W  text RAM address, row*COLS + col
- ram_data  in  8  char code; valid the cycle after ram_rd
- char  out  8  current character code
- x  out  $clog2(COL_WIDTH)  pixel column within cell
- y  out  $clog2(ROW_HEIGHT)  glyph scanline
- next_char  out  8  character code of the following cell
- next_y  out  $clog2(ROW_HEIGHT)  glyph scanline for next_char; always equals y
- enable  out  1  renderer enable; outputs are meaningful while high
- underrun  out  1  sticky; active arrived before the first character was loaded

## Operation
- States: IDLE, FETCH0, WAIT0, READY, RUN.
- Reset or frame_req: state=IDLE, row=0, row_base=0, y=0, col=0, x=0, char=next_char=BLANK_CHAR, ram_rd=0, ram_addr=0, enable=0. Reset also clears underrun; frame_req does not.
- line_req, in any state: goes to FETCH0. col=0, x=0. A line in progress is aborted and y is not advanced.
- FETCH0: ram_rd=1, ram_addr=row_base. Next state is WAIT0.
- WAIT0: char<=ram_data, next_char<=BLANK_CHAR. Next state is READY.
- READY, active=1: state=RUN.
- RUN, active=1: x increments each cycle.
  - At x==0 of column c with c+1<COLS: ram_rd=1, ram_addr=row_base+c+1.
  - At x==1: next_char<=ram_data.
  - At x==COL_WIDTH-1: char<=next_char, next_char<=BLANK_CHAR, col<=col+1, x wraps to 0.
  - At the last column, no fetch is issued and next_char stays BLANK_CHAR.
- RUN, active falling: state=IDLE.
  - y increments.
  - When y wraps at ROW_HEIGHT-1, row increments and row_base+=COLS. No multiplier is used.
  - When row wraps at ROWS-1, row=0 and row_base=0.
- enable = active && (state==READY || state==RUN); this is combinational from active.
- active=1 while in IDLE, FETCH0 or WAIT0: underrun<=1 and enable=0. The line is dropped with no y advance.
- frame_req and line_req in the same cycle: the frame reset applies first, then the line fetch starts at row 0.
- ram_addr is held when ram_rd=0.

## Timing
- line_req at cycle t: ram_rd at t+1, char valid at t+3. The earliest legal rise of active is t+3.
- char, x and y are valid in the same cycle as enable. The first active cycle shows x=0 and the col-0 char.
- next_char is valid from x==2 through x==COL_WIDTH-1 of each cell. The renderer samples it only at x==COL_WIDTH-1.
- Text RAM bandwidth is one read per COL_WIDTH cycles in RUN, plus one read per line.
- Outputs other than enable are registered.

## Test plan
- Setup for all cases: COLS=4, ROWS=2, ROW_HEIGHT=2, COL_WIDTH=8, RAM[i]=8'h41+i.
- One line: line_req, then active for 32 cycles at t+3. Required: char = 41,42,43,44, each held for 8 cycles with x=0..7. next_char = 42 at x=7 of col 0, and 20 in col 3. ram_addr = 0,1,2,3.
- Full frame of 4 lines: y = 0,1,0,1. The row-1 lines read addresses 4-7 and show chars 45-48. A second frame_req restarts at address 0.
- Early active: active rises at t+2. Required: underrun=1, enable=0 for the whole line, y unchanged. After a following correct line, underrun stays 1.
- Abort: line_req mid-line at col 2. Required: y not advanced, new fetch at row_base, char returns to the col-0 code.
- Reset mid-RUN: rst_n low for 1 cycle. Required: all outputs at their reset values immediately (enable=0, char=20, ram_rd=0, underrun=0).
- Simultaneous frame_req and line_req while on row 1: required fetch address 0.
